// File: rtl/ofs_fim_pcie_hdr_merge_if.sv
// ofs_fim_pcie_hdr_merge_if: PCIe SS AXI-S bundle used for header, payload and merged TLP streams
//   tvalid/tready  handshake
//   tdata/tkeep    beat data and byte enables
//   tlast          end of packet
//   tuser_vendor   sideband vendor bits
//   source modport drives a stream, sink modport receives it
interface ofs_fim_pcie_hdr_merge_if #(
  parameter int DATA_W = 512,
  parameter int USER_W = 10
);
  logic              tvalid;
  logic              tready;
  logic [DATA_W-1:0] tdata;
  logic [DATA_W/8-1:0] tkeep;
  logic              tlast;
  logic [USER_W-1:0] tuser_vendor;
  modport source(output tvalid, tdata, tkeep, tlast, tuser_vendor, input tready);
  modport sink(input tvalid, tdata, tkeep, tlast, tuser_vendor, output tready);
endinterface

// File: rtl/ofs_fim_pcie_hdr_merge.sv
// ofs_fim_pcie_hdr_merge: rebuild in-band PCIe SS TLPs from a sideband header stream and a bit-0 aligned payload stream
//   clk                 clock for all streams
//   rst_n               synchronous active-low reset
//   hdr_stream_source   one single-beat header per packet, header in the low half of tdata
//   data_stream_source  payload packet aligned at bit 0, empty TLP is one beat with tkeep=0
//   stream_sink         merged stream: header in low half of SOP beat, payload shifted up by half a bus
module ofs_fim_pcie_hdr_merge #(
  parameter int PL_DEPTH_OUT = 1,
  parameter int HDR_WIDTH    = 256
) (
  input logic                      clk,
  input logic                      rst_n,
  ofs_fim_pcie_hdr_merge_if.sink   hdr_stream_source,
  ofs_fim_pcie_hdr_merge_if.sink   data_stream_source,
  ofs_fim_pcie_hdr_merge_if.source stream_sink
);
  localparam int TDATA_WIDTH      = $bits(stream_sink.tdata);
  localparam int TKEEP_WIDTH      = TDATA_WIDTH / 8;
  localparam int USER_WIDTH       = $bits(stream_sink.tuser_vendor);
  localparam int HALF_TDATA_WIDTH = TDATA_WIDTH / 2;
  localparam int HALF_TKEEP_WIDTH = HALF_TDATA_WIDTH / 8;
  localparam int BW               = USER_WIDTH + 1 + TKEEP_WIDTH + TDATA_WIDTH;
  localparam logic [1:0] SOP   = 2'd0;
  localparam logic [1:0] BODY  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  if (TDATA_WIDTH != 2 * HDR_WIDTH || PL_DEPTH_OUT < 1) begin : g_bad_cfg
    $fatal(1, "ofs_fim_pcie_hdr_merge: TDATA_WIDTH must be 2*HDR_WIDTH and PL_DEPTH_OUT >= 1");
  end
  logic [1:0]                  state;
  logic [1:0]                  state_nx;
  logic [HALF_TDATA_WIDTH-1:0] prev_data;
  logic [HALF_TKEEP_WIDTH-1:0] prev_keep;
  logic                        sop;
  logic                        body;
  logic                        drain;
  logic                        hi_nz;
  logic                        m_valid;
  logic                        m_ready;
  logic                        m_fire;
  logic                        m_last;
  logic [TDATA_WIDTH-1:0]      m_data;
  logic [TKEEP_WIDTH-1:0]      m_keep;
  logic [USER_WIDTH-1:0]       m_user;
  logic [BW-1:0]               pd [PL_DEPTH_OUT+1];
  logic                        pv [PL_DEPTH_OUT+1];
  logic                        pr [PL_DEPTH_OUT+1];
  logic                        unused;
  assign unused = ^{hdr_stream_source.tdata[TDATA_WIDTH-1:HALF_TDATA_WIDTH], hdr_stream_source.tkeep,
                    hdr_stream_source.tlast, data_stream_source.tuser_vendor};
  assign sop   = state == SOP;
  assign body  = state == BODY;
  // any state that is neither SOP nor BODY behaves as DRAIN and recovers to SOP
  assign drain = !sop && !body;
  // a non-empty high half on the last payload beat spills into one extra output beat
  assign hi_nz = data_stream_source.tkeep[HALF_TKEEP_WIDTH];
  // reset gating keeps both input readies low during the reset cycle
  assign m_ready = pr[0] && rst_n;
  assign m_fire  = m_valid && m_ready;
  always_comb begin
    m_valid  = sop ? hdr_stream_source.tvalid && data_stream_source.tvalid
             : body ? data_stream_source.tvalid : 1'b1;
    m_last   = drain ? 1'b1 : data_stream_source.tlast && !hi_nz;
    m_data   = drain ? {{HALF_TDATA_WIDTH{1'b0}}, prev_data}
             : {data_stream_source.tdata[HALF_TDATA_WIDTH-1:0],
                sop ? hdr_stream_source.tdata[HALF_TDATA_WIDTH-1:0] : prev_data};
    m_keep   = drain ? {{HALF_TKEEP_WIDTH{1'b0}}, prev_keep}
             : {data_stream_source.tkeep[HALF_TKEEP_WIDTH-1:0],
                sop ? {HALF_TKEEP_WIDTH{1'b1}} : prev_keep};
    m_user   = sop ? hdr_stream_source.tuser_vendor : '0;
    state_nx = drain ? SOP : !data_stream_source.tlast ? BODY : hi_nz ? DRAIN : SOP;
  end
  assign hdr_stream_source.tready  = sop && data_stream_source.tvalid && m_ready;
  assign data_stream_source.tready = ((sop && hdr_stream_source.tvalid) || body) && m_ready;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= SOP;
      prev_data <= '0;
      prev_keep <= '0;
    end else if (m_fire) begin
      state <= state_nx;
      if (!drain) begin
        prev_data <= data_stream_source.tdata[TDATA_WIDTH-1:HALF_TDATA_WIDTH];
        prev_keep <= data_stream_source.tkeep[TKEEP_WIDTH-1:HALF_TKEEP_WIDTH];
      end
    end
  end
  assign pd[0] = {m_user, m_last, m_keep, m_data};
  assign pv[0] = m_valid;
  // each stage is an output register plus one skid entry so ready never depends on downstream combinationally
  for (genvar g = 0; g < PL_DEPTH_OUT; g++) begin : g_stage
    logic [BW-1:0] out_d;
    logic [BW-1:0] skid_d;
    logic          out_v;
    logic          skid_v;
    assign pr[g]   = !skid_v;
    assign pv[g+1] = out_v;
    assign pd[g+1] = out_d;
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        out_v  <= 1'b0;
        skid_v <= 1'b0;
        out_d  <= '0;
        skid_d <= '0;
      end else if (!out_v || pr[g+1]) begin
        out_v  <= skid_v || pv[g];
        out_d  <= skid_v ? skid_d : pd[g];
        skid_v <= 1'b0;
      end else if (pv[g] && !skid_v) begin
        skid_v <= 1'b1;
        skid_d <= pd[g];
      end
    end
  end
  assign pr[PL_DEPTH_OUT] = stream_sink.tready;
  assign stream_sink.tvalid = pv[PL_DEPTH_OUT];
  assign {stream_sink.tuser_vendor, stream_sink.tlast, stream_sink.tkeep, stream_sink.tdata} = pd[PL_DEPTH_OUT];
endmodule
